// File: rtl/proc_pkg.sv
// Shared types and instruction field positions for the multi-cycle core.
package proc_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_LW   = 4'h1,
        OP_SW   = 4'h2,
        OP_BEQ  = 4'h3,
        OP_BGT  = 4'h4,
        OP_BGE  = 4'h5,
        OP_JUMP = 4'h6,
        OP_LI   = 4'h7,
        OP_MUL  = 4'h8,
        OP_HALT = 4'hF
    } opcode_e;

    typedef enum logic [1:0] {
        S_FETCH,
        S_EXEC,
        S_MEM,
        S_HALT
    } state_e;

    localparam int OPC_LSB    = 0;
    localparam int OPC_W      = 4;
    localparam int RD_LSB     = 4;
    localparam int RB_LSB     = 9;
    localparam int RA_LSB     = 14;
    localparam int REG_IDX_W  = 5;
    localparam int IMM_LSB    = 9;
    localparam int IMM_W      = 23;
    localparam int OFF_HI_LSB = 19;
    localparam int OFF_W      = 18;

endpackage

// File: rtl/proc_regfile.sv
// Register file: two combinational read ports, one synchronous write port.
// Indices at or above NREGS read as zero and discard writes.
module proc_regfile
    import proc_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [REG_IDX_W-1:0] ra_addr,
    input  logic [REG_IDX_W-1:0] rb_addr,
    output logic [DATA_W-1:0]    ra_data,
    output logic [DATA_W-1:0]    rb_data,
    input  logic                 we,
    input  logic [REG_IDX_W-1:0] waddr,
    input  logic [DATA_W-1:0]    wdata
);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];

    always_comb begin
        regs_d = regs_q;
        if (we && (int'(waddr) < NREGS)) begin
            regs_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign ra_data = (int'(ra_addr) < NREGS) ? regs_q[ra_addr] : '0;
    assign rb_data = (int'(rb_addr) < NREGS) ? regs_q[rb_addr] : '0;

endmodule

// File: rtl/proc_mc_core.sv
// Multi-cycle FETCH/EXEC/MEM core with handshaked instruction and data ports.
// Optional macro PROC_MUL_EN enables opcode 8 (MUL); otherwise it is a NOP.
module proc_mc_core
    import proc_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int PC_W   = 12,
    parameter int NREGS  = 32
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              imem_ack,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [PC_W-1:0]   dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic [PC_W-1:0]   pc,
    output logic              taken,
    output logic              halted
);

    state_e                state_q, state_d;
    logic [PC_W-1:0]       pc_q, pc_d;
    logic [31:0]           instr_q, instr_d;

    logic [OPC_W-1:0]      opc;
    logic [REG_IDX_W-1:0]  rd_idx, ra_idx, rb_idx;
    logic [DATA_W-1:0]     ra_val, rb_val, imm_ext, wb_data;
    logic [OFF_W-1:0]      off18;
    logic [PC_W-1:0]       off_pc, pc_inc, pc_br;
    logic                  wb_en, take;

    assign opc     = instr_q[OPC_LSB +: OPC_W];
    assign rd_idx  = instr_q[RD_LSB +: REG_IDX_W];
    assign rb_idx  = instr_q[RB_LSB +: REG_IDX_W];
    assign ra_idx  = instr_q[RA_LSB +: REG_IDX_W];
    assign imm_ext = {{(DATA_W-IMM_W){instr_q[31]}}, instr_q[IMM_LSB +: IMM_W]};
    assign off18   = {instr_q[31:OFF_HI_LSB], rd_idx};
    assign off_pc  = PC_W'($signed(off18));
    assign pc_inc  = pc_q + PC_W'(1);
    assign pc_br   = pc_q + off_pc;

    proc_regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_rf (
        .clk     (clk),
        .reset   (reset),
        .ra_addr (ra_idx),
        .rb_addr (rb_idx),
        .ra_data (ra_val),
        .rb_data (rb_val),
        .we      (wb_en),
        .waddr   (rd_idx),
        .wdata   (wb_data)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        wb_en   = 1'b0;
        wb_data = ra_val + rb_val;
        take    = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = S_FETCH;
                pc_d    = pc_inc;
                case (opc)
                    OP_ADD:  wb_en = 1'b1;
                    OP_LW, OP_SW: begin
                        pc_d    = pc_q;
                        state_d = S_MEM;
                    end
                    OP_BEQ:  take = (ra_val == rb_val);
                    OP_BGT:  take = ($signed(ra_val) >  $signed(rb_val));
                    OP_BGE:  take = ($signed(ra_val) >= $signed(rb_val));
                    OP_JUMP: begin
                        take = 1'b1;
                        pc_d = ra_val[PC_W-1:0];
                    end
                    OP_LI: begin
                        wb_en   = 1'b1;
                        wb_data = imm_ext;
                    end
`ifdef PROC_MUL_EN
                    OP_MUL: begin
                        wb_en   = 1'b1;
                        wb_data = ra_val * rb_val;
                    end
`endif
                    OP_HALT: begin
                        pc_d    = pc_q;
                        state_d = S_HALT;
                    end
                    default: ;
                endcase
                if (take && (opc != OP_JUMP)) begin
                    pc_d = pc_br;
                end
            end
            S_MEM: begin
                if (dmem_ack) begin
                    wb_en   = (opc == OP_LW);
                    wb_data = dmem_rdata;
                    pc_d    = pc_inc;
                    state_d = S_FETCH;
                end
            end
            S_HALT: ;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    // Request/status outputs are masked while reset is held so nothing is issued before release.
    assign imem_req   = (state_q == S_FETCH) && !reset;
    assign imem_addr  = pc_q;
    assign dmem_req   = (state_q == S_MEM) && !reset;
    assign dmem_we    = dmem_req && (opc == OP_SW);
    assign dmem_addr  = rb_val[PC_W-1:0] + off_pc;
    assign dmem_wdata = ra_val;
    assign pc         = pc_q;
    assign taken      = (state_q == S_EXEC) && take && !reset;
    assign halted     = (state_q == S_HALT) && !reset;

endmodule

// File: tb/tb_proc_mc_core.sv
// Directed, table-driven bench for proc_mc_core plus hand sequences for memory, reset and halt.
module tb_proc_mc_core;

    localparam int DATA_W = 32;
    localparam int PC_W   = 12;
    localparam int NREGS  = 32;

`ifdef PROC_MUL_EN
    localparam logic [31:0] MUL_EXP = 32'hFFFF_FFF4;
`else
    localparam logic [31:0] MUL_EXP = 32'h0000_0000;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              imem_req;
    logic [PC_W-1:0]   imem_addr;
    logic [31:0]       imem_rdata;
    logic              imem_ack;
    logic              dmem_req;
    logic              dmem_we;
    logic [PC_W-1:0]   dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic [DATA_W-1:0] dmem_rdata;
    logic              dmem_ack;
    logic [PC_W-1:0]   pc;
    logic              taken;
    logic              halted;

    proc_mc_core #(
        .DATA_W (DATA_W),
        .PC_W   (PC_W),
        .NREGS  (NREGS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ack   (imem_ack),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_ack   (dmem_ack),
        .pc         (pc),
        .taken      (taken),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]     instr;
        logic            exp_taken;
        logic [PC_W-1:0] exp_pc;
        int              chk_reg;
        logic [31:0]     exp_val;
    } vec_t;

    vec_t            vecs[$];
    int              checks = 0;
    int              errors = 0;
    logic [PC_W-1:0] cur_pc;
    logic [31:0]     mem_word;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rf(input int i);
        return dut.u_rf.regs_q[i];
    endfunction

    function automatic logic [31:0] enc_r(input logic [3:0] op, input logic [4:0] rd,
                                          input logic [4:0] ra, input logic [4:0] rb);
        return {13'd0, ra, rb, rd, op};
    endfunction

    function automatic logic [31:0] enc_li(input logic [4:0] rd, input logic [22:0] imm);
        return {imm, rd, 4'h7};
    endfunction

    function automatic logic [31:0] enc_br(input logic [3:0] op, input logic [4:0] ra,
                                           input logic [4:0] rb, input int off);
        logic [17:0] o;
        o = 18'(off);
        return {o[17:5], ra, rb, o[4:0], op};
    endfunction

    function automatic void addv(input logic [31:0] instr, input logic tk,
                                 input logic [PC_W-1:0] npc, input int r, input logic [31:0] v);
        vec_t e;
        e.instr = instr; e.exp_taken = tk; e.exp_pc = npc; e.chk_reg = r; e.exp_val = v;
        vecs.push_back(e);
    endfunction

    // Entered at a negedge; returns at the negedge of the EXEC cycle.
    task automatic fetch(input logic [31:0] instr, input logic [PC_W-1:0] exp_addr, input int wait_cyc);
        int guard = 0;
        while (imem_req !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("fetch_req", {31'd0, imem_req}, 32'd1);
        chk("fetch_addr", {20'd0, imem_addr}, {20'd0, exp_addr});
        for (int i = 0; i < wait_cyc; i++) begin
            @(negedge clk);
            chk("fetch_hold", {19'd0, imem_req, imem_addr}, {19'd0, 1'b1, exp_addr});
        end
        imem_rdata = instr;
        imem_ack   = 1'b1;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = '0;
    endtask

    task automatic run_plain(input logic [31:0] instr, input logic [PC_W-1:0] npc);
        fetch(instr, cur_pc, 0);
        @(negedge clk);
        chk("plain_pc", {20'd0, pc}, {20'd0, npc});
        cur_pc = npc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; imem_ack = 1'b0; imem_rdata = '0; dmem_ack = 1'b0; dmem_rdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
        chk("rst_dmem_req", {30'd0, dmem_req, dmem_we}, 32'd0);
        chk("rst_pc", {20'd0, pc}, 32'd0);
        chk("rst_flags", {30'd0, taken, halted}, 32'd0);
        chk("rst_reg5", rf(5), 32'd0);
        reset = 1'b0;
        cur_pc = '0;

        addv(enc_li(5, 23'd9),          1'b0, 12'h001, 5,  32'd9);
        addv(enc_li(6, 23'd9),          1'b0, 12'h002, 6,  32'd9);
        addv(enc_li(7, 23'd8),          1'b0, 12'h003, 7,  32'd8);
        addv(enc_li(1, 23'd5),          1'b0, 12'h004, 1,  32'd5);
        addv(enc_br(4'h3, 5, 6, -2),    1'b1, 12'h002, -1, 32'd0);
        addv(enc_li(2, 23'd7),          1'b0, 12'h003, 2,  32'd7);
        addv(enc_r(4'h0, 3, 1, 2),      1'b0, 12'h004, 3,  32'd12);
        addv(enc_br(4'h3, 5, 7, -2),    1'b0, 12'h005, -1, 32'd0);
        addv(enc_li(4, 23'h7FFFFF),     1'b0, 12'h006, 4,  32'hFFFF_FFFF);
        addv(enc_br(4'h4, 5, 7, 3),     1'b1, 12'h009, -1, 32'd0);
        addv(enc_br(4'h5, 7, 5, 5),     1'b0, 12'h00A, -1, 32'd0);
        addv(enc_br(4'h4, 4, 1, 5),     1'b0, 12'h00B, -1, 32'd0);
        addv(enc_br(4'h5, 5, 6, -11),   1'b1, 12'h000, -1, 32'd0);
        addv(enc_li(8, 23'h1234),       1'b0, 12'h001, 8,  32'h1234);
        addv(enc_r(4'h6, 0, 8, 0),      1'b1, 12'h234, -1, 32'd0);
        addv(32'h0000_0009,             1'b0, 12'h235, -1, 32'd0);
        addv(enc_li(9, 23'd3),          1'b0, 12'h236, 9,  32'd3);
        addv(enc_li(10, 23'h7FFFFC),    1'b0, 12'h237, 10, 32'hFFFF_FFFC);
        addv(enc_r(4'h8, 11, 9, 10),    1'b0, 12'h238, 11, MUL_EXP);
        addv(enc_li(12, 23'hFFF),       1'b0, 12'h239, 12, 32'hFFF);
        addv(enc_r(4'h6, 0, 12, 0),     1'b1, 12'hFFF, -1, 32'd0);
        addv(enc_r(4'h0, 13, 9, 9),     1'b0, 12'h000, 13, 32'd6);
        addv(enc_br(4'h3, 0, 0, -1),    1'b1, 12'hFFF, -1, 32'd0);
        addv(enc_r(4'h0, 14, 4, 9),     1'b0, 12'h000, 14, 32'd2);

        foreach (vecs[i]) begin
            fetch(vecs[i].instr, cur_pc, i % 3);
            chk($sformatf("v%0d_taken", i), {31'd0, taken}, {31'd0, vecs[i].exp_taken});
            @(negedge clk);
            chk($sformatf("v%0d_pc", i), {20'd0, pc}, {20'd0, vecs[i].exp_pc});
            chk($sformatf("v%0d_refetch", i), {31'd0, imem_req}, 32'd1);
            if (vecs[i].chk_reg >= 0)
                chk($sformatf("v%0d_r%0d", i, vecs[i].chk_reg), rf(vecs[i].chk_reg), vecs[i].exp_val);
            cur_pc = vecs[i].exp_pc;
        end

        // SW r1 -> [r2+3] with a 3-cycle ack delay; address wraps to 0x001.
        run_plain(enc_li(1, 23'hABCD), cur_pc + 12'd1);
        run_plain(enc_li(2, 23'hFFE), cur_pc + 12'd1);
        fetch(enc_br(4'h2, 1, 2, 3), cur_pc, 0);
        chk("sw_exec_noreq", {31'd0, dmem_req}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("sw_req_we", {30'd0, dmem_req, dmem_we}, 32'd3);
            chk("sw_addr", {20'd0, dmem_addr}, 32'h001);
            chk("sw_wdata", dmem_wdata, 32'hABCD);
            chk("sw_pc_hold", {20'd0, pc}, {20'd0, cur_pc});
        end
        mem_word = dmem_wdata;
        dmem_ack = 1'b1;
        @(negedge clk);
        dmem_ack = 1'b0;
        chk("sw_done_pc", {20'd0, pc}, {20'd0, cur_pc + 12'd1});
        chk("sw_done_fetch", {30'd0, imem_req, dmem_req}, 32'd2);
        cur_pc = cur_pc + 12'd1;

        // LW r3 <- [r2+3] with same-cycle ack.
        fetch(enc_br(4'h1, 0, 2, 3), cur_pc, 0);
        @(negedge clk);
        chk("lw_req_we", {30'd0, dmem_req, dmem_we}, 32'd2);
        chk("lw_addr", {20'd0, dmem_addr}, 32'h001);
        dmem_rdata = mem_word;
        dmem_ack   = 1'b1;
        @(negedge clk);
        dmem_ack   = 1'b0;
        chk("lw_r3", rf(3), 32'hABCD);
        chk("lw_pc", {20'd0, pc}, {20'd0, cur_pc + 12'd1});
        chk("lw_refetch", {31'd0, imem_req}, 32'd1);
        cur_pc = cur_pc + 12'd1;

        // Reset while MEM is pending; the late ack must not write r3.
        fetch(enc_br(4'h1, 0, 2, 3), cur_pc, 0);
        @(negedge clk);
        chk("rm_in_mem", {31'd0, dmem_req}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("rm_rst_reqs", {29'd0, imem_req, dmem_req, dmem_we}, 32'd0);
        chk("rm_rst_pc", {20'd0, pc}, 32'd0);
        reset      = 1'b0;
        dmem_rdata = 32'h5555;
        dmem_ack   = 1'b1;
        @(negedge clk);
        dmem_ack   = 1'b0;
        chk("rm_r3", rf(3), 32'd0);
        chk("rm_pc", {20'd0, pc}, 32'd0);
        chk("rm_imem_req", {30'd0, imem_req, dmem_req}, 32'd2);
        cur_pc = '0;

        // Walk to pc=6 and halt; requests must stay quiet despite stray acks.
        for (int i = 0; i < 6; i++) run_plain(32'h0000_0009, cur_pc + 12'd1);
        fetch(32'h0000_000F, cur_pc, 1);
        chk("halt_exec_taken", {31'd0, taken}, 32'd0);
        for (int i = 0; i < 20; i++) begin
            imem_ack = (i % 2 == 0);
            dmem_ack = (i % 3 == 0);
            @(negedge clk);
            chk("halt_reqs", {30'd0, imem_req, dmem_req}, 32'd0);
            chk("halt_flag", {31'd0, halted}, 32'd1);
            chk("halt_pc", {20'd0, pc}, 32'd6);
        end
        imem_ack = 1'b0;
        dmem_ack = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
